// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order requests to a
// synchronous-read instruction memory and presents (pc, instr) pairs to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } slot_t;

  slot_t       slots [2];
  logic [31:0] fetch_pc;
  logic        head;
  logic        tail;
  logic [1:0]  count;
  logic [1:0]  drop_cnt;

  logic        second;
  logic        head_unfilled;
  logic        second_unfilled;
  logic        pop;
  logic        alloc;
  logic        fill;
  logic        fill_idx;
  logic [2:0]  occupancy;
  logic [2:0]  unfilled;
  logic [2:0]  drop_sum;
  logic [2:0]  drop_next;

  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here at the
    // top of the block) so no latch can be inferred.
    second          = ~head;
    head_unfilled   = (count != 2'd0) && !slots[head].filled;
    second_unfilled = (count == 2'd2) && !slots[second].filled;

    if_valid = (count != 2'd0) && slots[head].filled;
    if_pc    = if_valid ? slots[head].pc    : 32'h0;
    if_instr = if_valid ? slots[head].instr : 32'h0000_0000;

    // A redirect squashes the presented instruction, so it never pops.
    pop = if_valid && !stall && !redirect;

    // Slots plus responses still owed to us must leave room for one more.
    occupancy      = {1'b0, count} + {1'b0, drop_cnt};
    imem_req_valid = !rst && !redirect && (occupancy < (3'd2 + {2'b00, pop}));
    imem_req_addr  = fetch_pc;
    alloc          = imem_req_valid && imem_req_ready;

    // In-order returns: the oldest unfilled slot is the head if it is still
    // waiting, otherwise the slot behind it.
    fill     = imem_resp_valid && (drop_cnt == 2'd0) && !redirect && !rst;
    fill_idx = head_unfilled ? head : second;

    unfilled  = {2'b00, head_unfilled} + {2'b00, second_unfilled};
    drop_sum  = {1'b0, drop_cnt} + unfilled;
    drop_next = (imem_resp_valid && (drop_sum != 3'd0)) ? drop_sum - 3'd1 : drop_sum;
  end

  // NOTE: slot payload is deliberately not reset; a slot is only read once
  // count covers it, and allocation clears its filled bit first.
  always_ff @(posedge clk) begin
    if (alloc) begin
      slots[tail].pc     <= fetch_pc;
      slots[tail].instr  <= 32'h0000_0000;
      slots[tail].filled <= 1'b0;
    end
    if (fill) begin
      slots[fill_idx].instr  <= imem_resp_data;
      slots[fill_idx].filled <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      head     <= 1'b0;
      tail     <= 1'b0;
      count    <= 2'd0;
      drop_cnt <= 2'd0;
    end else if (redirect) begin
      // Empty the buffer; every unfilled slot becomes a response to discard.
      head     <= tail;
      count    <= 2'd0;
      drop_cnt <= drop_next[1:0];
      fetch_pc <= {redirect_pc[31:2], 2'b00};
    end else begin
      if (alloc) begin
        tail     <= ~tail;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        head <= ~head;
      end
      count <= count + {1'b0, alloc} - {1'b0, pop};
      if (imem_resp_valid && (drop_cnt != 2'd0)) begin
        drop_cnt <= drop_cnt - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural instruction memory with
// configurable latency, expected (pc, instr) pairs queued on each accepted fetch.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .stall           (stall),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          errors  = 0;
  int          cyc     = 0;
  int          lat     = 1;
  int          pops    = 0;
  int          first_accept = -1;
  int          first_pop    = -1;
  int          redir_cyc    = 0;
  bit          after_redir  = 1'b0;
  bit          chk_noreq    = 1'b0;
  bit          prev_hold    = 1'b0;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;
  logic [31:0] exp_fetch;
  exp_t        exp_q [$];
  resp_t       pend  [$];

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy);
    exp_t  e;
    resp_t r;
    stall          = st;
    redirect       = rd;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = r.data;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
    #1;
    if (prev_hold) begin
      check("hold_valid", {31'b0, if_valid}, 32'd1);
      check("hold_pc", if_pc, hold_pc);
      check("hold_instr", if_instr, hold_instr);
    end
    prev_hold  = if_valid && st && !rd;
    hold_pc    = if_pc;
    hold_instr = if_instr;
    if (rd) check("req_in_redirect", {31'b0, imem_req_valid}, 32'd0);
    if (chk_noreq) check("req_while_full", {31'b0, imem_req_valid}, 32'd0);
    if (if_valid && !st && !rd) begin
      pops++;
      if (first_pop < 0) first_pop = cyc;
      if (exp_q.size() == 0) begin
        check("pop_unexpected", {31'b0, if_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("if_pc", if_pc, e.pc);
        check("if_instr", if_instr, e.instr);
      end
      if (after_redir) begin
        check("redirect_latency", {31'b0, cyc >= redir_cyc + 3}, 32'd1);
        after_redir = 1'b0;
      end
    end
    if (rd) begin
      exp_q.delete();
      exp_fetch   = rpc & ~32'h3;
      redir_cyc   = cyc;
      after_redir = 1'b1;
    end
    if (imem_req_valid && rdy) begin
      if (first_accept < 0) first_accept = cyc;
      check("req_addr", imem_req_addr, exp_fetch);
      check("outstanding", {31'b0, pend.size() + 1 <= 2}, 32'd1);
      r.due  = cyc + lat;
      r.data = mem_word(imem_req_addr);
      pend.push_back(r);
      e.pc    = imem_req_addr;
      e.instr = r.data;
      exp_q.push_back(e);
      exp_fetch = exp_fetch + 32'd4;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int p0;
    logic        st;
    logic        rd;
    logic [31:0] rpc;

    rst = 1'b1;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    exp_fetch = RST_PC;
    repeat (3) @(negedge clk);
    check("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    rst = 1'b0;

    // Streaming from reset, including the wrap past 32'hFFFF_FFFC.
    repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1);
    check("first_req_cycle", first_accept, 0);
    check("first_valid_latency", first_pop - first_accept, 2);
    check("throughput", pops, 10);

    // Decode stall with a full buffer: hold output, stop requesting.
    chk_noreq = 1'b1;
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
    chk_noreq = 1'b0;
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirects with responses in flight, including one to an unaligned target.
    lat = 2;
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0100, 1'b1);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
    lat = 1;
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0203, 1'b1);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Slow memory, toggling ready, random stalls and occasional redirects.
    lat = 3;
    p0  = pops;
    for (int i = 0; i < 800 && (pops - p0) < 50; i++) begin
      st  = ($urandom % 5) == 0;
      rd  = ($urandom % 40) == 0;
      rpc = $urandom & 32'h0000_0FFF;
      step(st, rd, rpc, cyc[0]);
    end
    check("random_progress", {31'b0, (pops - p0) >= 50}, 32'd1);

    // Reset in the middle of a stream.
    lat = 1;
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_if_valid", {31'b0, if_valid}, 32'd0);
    check("midrst_if_pc", if_pc, 32'h0);
    check("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    pend.delete();
    exp_q.delete();
    exp_fetch   = RST_PC;
    prev_hold   = 1'b0;
    after_redir = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Stop fetching; everything accepted must come out.
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b0);
    check("drain_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 5-stage pipeline. It feeds the IF/ID pipeline register with (PC, instruction) pairs and owns the fetch PC. It also owns the request/response handshake to a synchronous-read instruction memory. A 2-entry in-order slot buffer absorbs memory latency and decode stalls, and it redirects to `redirect_pc` when the execute/memory stage resolves a taken branch or jump.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.

Ports:
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset is asynchronous and active-high.
- `imem_req_valid` output, 1 bit: fetch request valid.
- `imem_req_ready` input, 1 bit: memory accepts the request this cycle.
- `imem_req_addr` output, 32 bits: word-aligned fetch address.
- `imem_resp_valid` input, 1 bit: returned instruction valid.
  - Responses come in request order, at least 1 cycle after acceptance.
  - Responses are never back-pressured.
- `imem_resp_data` input, 32 bits: returned instruction.
- `redirect` input, 1 bit: taken branch/jump, asserted for one cycle per event.
- `redirect_pc` input, 32 bits: redirect target; bits [1:0] are forced to 0 internally.
- `stall` input, 1 bit: decode cannot accept; hold the current output.
- `if_valid` output, 1 bit: `if_pc`/`if_instr` are valid.
- `if_pc` output, 32 bits: PC of the presented instruction.
- `if_instr` output, 32 bits: presented instruction.

## Operation
- State:
  - `fetch_pc` (32 bits).
  - 2-entry circular slot buffer, each entry {pc[31:0], instr[31:0], filled}; head/tail pointers and `count` (0..2).
  - `drop_cnt` (0..2): in-flight responses that must be discarded.
- Request:
  - `imem_req_addr = fetch_pc`.
  - `imem_req_valid = !redirect && (count + drop_cnt - pop) < 2`, where `pop = if_valid && !stall`.
  - On accept (valid && ready): allocate the tail slot with pc=`fetch_pc`, filled=0, then `fetch_pc <= fetch_pc + 4`.
  - `fetch_pc` wraps modulo 2^32; 32'hFFFF_FFFC is followed by 0.
- Response:
  - If `drop_cnt > 0`: discard the data and decrement `drop_cnt`.
  - Otherwise: write the data into the oldest unfilled slot and set filled=1.
  - Outstanding requests never exceed 2, so a response always has a slot.
- Output:
  - `if_valid` = head slot valid && filled.
  - When `if_valid`, `if_pc`/`if_instr` show the head slot contents; otherwise 32'h0 and 32'h0000_0000 (NOP).
  - Pop on `if_valid && !stall`: advance the head and decrement `count`.
  - While `stall` is high, the outputs are held stable.
- Redirect (highest priority):
  - Drop all slots: `count <= 0`.
  - `drop_cnt <= drop_cnt + unfilled_slots - (imem_resp_valid ? 1 : 0)`, i.e. a response arriving in the redirect cycle is itself discarded.
  - `fetch_pc <= {redirect_pc[31:2], 2'b00}`.
  - No request is issued in the redirect cycle, and no pop occurs (the presented instruction is squashed regardless of `stall`).
- Simultaneous events without redirect:
  - Pop, allocate and fill in the same cycle are all honoured.
  - A fill may target the slot being allocated only if a response cannot arrive in its own request cycle; that never happens by protocol.

## Timing
- Values while `rst` is high, and immediately on its assertion:
  - `fetch_pc = RESET_PC`; `count = 0`; `drop_cnt = 0`; pointers = 0.
  - `if_valid = 0`; `if_pc = 0`; `if_instr = 0`.
  - `imem_req_valid` is forced to 0.
- First request is in the first cycle after `rst` deasserts.
- Latency: with a 1-cycle memory, request in cycle N gives `if_valid` in cycle N+2.
- Throughput: 1 instruction/cycle sustained with a 1-cycle memory, no stalls and `imem_req_ready` = 1.
- Reset asserted mid-operation: all slots and `drop_cnt` clear immediately. Responses still in flight must be suppressed by the memory's own reset; the block does not track them.
- Redirect in cycle N: the target request is issued in cycle N+1 (if ready), and the target is presented no earlier than cycle N+3.

## Test plan
- Reset release, 1-cycle memory, ready=1, no stall -> requests 0x0, 0x4, 0x8… on consecutive cycles; `if_valid` from cycle 2; `if_pc` = 0x0, 0x4, 0x8 one per cycle with matching data.
- `stall` high for 3 cycles while presenting 0x8 -> `if_pc`/`if_instr` held at 0x8; `imem_req_valid` drops once buffer+outstanding = 2; resumes with 0xC, no duplicate or lost instruction.
- `redirect` to 0x100 with 2 requests in flight (one response landing in the redirect cycle) -> both old responses discarded; next `if_pc` = 0x100, then 0x104.
- `redirect_pc` = 0x203 -> fetch issued at 0x200.
- `imem_req_ready` toggling 0/1 every cycle and 3-cycle response latency -> in-order PCs, no gaps or repeats over 50 instructions; outstanding never > 2.
- `RESET_PC` = 32'hFFFF_FFF8 -> PCs FFFF_FFF8, FFFF_FFFC, 0000_0000; `rst` asserted mid-stream -> `if_valid` = 0 immediately; restart at `RESET_PC`.
